qos_packet_arbiter: RTL and testbench
=====================================

# qos_packet_arbiter

Packet-level N-to-1 stream arbiter with QoS priority, round-robin fairness within the winning priority class, and a registered master output. A grant is held for a whole packet, from first beat to the beat with `last`, so packets never interleave. It sits in front of shared egress links, as the parametrised successor of the 2-stream QoS arbiter, with wider QoS, any stream count, a registered output and optional anti-starvation aging.

## Interface
- `T_DATA_WIDTH`, 32, payload width.
- `T_QOS_WIDTH`, 4, QoS field width; larger value means higher priority; 0 is best-effort.
- `STREAM_COUNT`, 4, number of slave streams, ≥1.
- `T_ID_WIDTH`, `STREAM_COUNT>1 ? $clog2(STREAM_COUNT) : 1`, width of the stream ID.
- `AGE_LIMIT`, 15, arbitration losses before a stream is promoted (aging builds only), ≥1.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `s_data_in`  in  `[STREAM_COUNT][T_DATA_WIDTH]`  per-stream payload.
- `s_qos_in`  in  `[STREAM_COUNT][T_QOS_WIDTH]`  per-stream priority; sampled only at grant.
- `s_last_in`  in  `STREAM_COUNT`  end-of-packet marker.
- `s_valid_in`  in  `STREAM_COUNT`  beat valid.
- `s_ready_out`  out  `STREAM_COUNT`  beat accepted when valid&ready; one-hot or zero.
- `m_data_out`  out  `T_DATA_WIDTH`  registered payload.
- `m_qos_out`  out  `T_QOS_WIDTH`  QoS latched at grant; constant for the whole packet.
- `m_id_out`  out  `T_ID_WIDTH`  granted stream index.
- `m_last_out`  out  1  registered last.
- `m_valid_out`  out  1  output beat valid.
- `m_ready_in`  in  1  downstream ready.

## Operation
- FSM states are `IDLE` and `LOCKED`.
- In `IDLE`, `max_qos` is the maximum `s_qos_in` over valid streams, and `cand = s_valid_in & (qos==max_qos)`.
- The winner is the first set bit of `cand` scanning `rr_ptr+1, rr_ptr+2, …` modulo `STREAM_COUNT`.
- If any candidate exists, on the next edge: go to `LOCKED`, latch `sel`, and latch `sel_qos = s_qos_in[sel]`.
- The grant does not depend on `m_ready_in`.
- In `LOCKED`, `s_ready_out[sel] = !m_valid_out || m_ready_in`, and all other ready bits are 0.
- An accepted beat loads `m_data_out`, `m_last_out`, `m_id_out=sel` and `m_qos_out=sel_qos`, and sets `m_valid_out`.
- `m_valid_out` clears when `m_ready_in` is high and no new beat is loaded.
- When an accepted slave beat has `last=1`: go to `IDLE` and set `rr_ptr <= sel`.
- While `m_valid_out && !m_ready_in`, all `m_*` outputs hold stable.
- If the granted stream drops valid mid-packet, the block stays `LOCKED` and waits; there is no timeout.
- QoS changes mid-packet are ignored.
- A single-beat packet (last on the first beat) is legal.
- With `STREAM_COUNT=1`, the block is pass-through with the same latency and `m_id_out=0`.

## Timing
- Reset values: state `IDLE`, `rr_ptr=STREAM_COUNT-1` (stream 0 wins the first tie), `s_ready_out=0`, `m_valid_out=0`, `m_data_out=0`, `m_qos_out=0`, `m_id_out=0`, `m_last_out=0`, all age counters 0.
- Latency: valid in cycle 0 (IDLE) → grant edge → ready in cycle 1 → `m_valid_out` in cycle 2.
- Within a packet, throughput is 1 beat/cycle while `m_ready_in=1`.
- There is exactly one `IDLE` bubble cycle between packets.
- Reset asserted mid-packet aborts immediately, with no flush; the partial packet is lost.
- Simultaneous events:
  - Last-beat accept and downstream stall do not conflict; the output register holds the last beat and the FSM still moves to `IDLE`.
  - Arbitration in the following `IDLE` cycle proceeds regardless of `m_ready_in`.

## Configuration
- Macro: `QOS_ARB_AGING_EN`.
- Defined:
  - Each stream has an age counter of width `$clog2(AGE_LIMIT+1)`.
  - The counter increments, saturating at `AGE_LIMIT`, on each `IDLE` grant edge where the stream is valid but not selected.
  - The counter clears when the stream is granted.
  - A stream with `age==AGE_LIMIT` is treated as QoS all-ones for the `max_qos`/`cand` computation only.
  - `m_qos_out` still reports the stream's real QoS.
  - Among aged streams, the normal round-robin order applies.
- Undefined: strict QoS priority with no counters. Low-QoS streams may starve indefinitely.

## Test plan
- Reset, then stream 0 sends a 3-beat packet with qos=2 → `m_valid_out` in cycle 2; data in order; `m_id_out=0`; `m_last_out` on beat 3; one bubble before the next grant.
- Streams 1 and 3 are valid with qos 1 and 5 → stream 3 packet first, entirely, then stream 1; `m_qos_out` reads 5 then 1.
- Streams 0–3 all valid at equal qos with 1-beat packets, repeated → grant order 0,1,2,3,0.
- `m_ready_in` toggles 1,0,0,1 during a packet, and the source drops valid mid-packet for 2 cycles → no beat lost or duplicated; `m_*` stable while stalled; no other stream is granted.
- Aging build, `AGE_LIMIT=3`: stream 1 at qos=0, stream 2 continuously at qos=7 → stream 1 granted on the 4th arbitration, with `m_qos_out=0`. Non-aging build, same stimulus → stream 1 is never granted.
- `rst_n` low mid-packet → all outputs at reset values asynchronously; after release, the first grant goes to the lowest valid index.

Source files
------------

// File: rtl/qos_packet_arbiter.sv
// Packet-level N-to-1 stream arbiter: QoS priority, round-robin among equal QoS, registered master side.
// Define QOS_ARB_AGING_EN to promote streams that lose AGE_LIMIT arbitrations in a row.
module qos_packet_arbiter #(
    parameter int unsigned T_DATA_WIDTH = 32,
    parameter int unsigned T_QOS_WIDTH  = 4,
    parameter int unsigned STREAM_COUNT = 4,
    parameter int unsigned T_ID_WIDTH   = (STREAM_COUNT > 1) ? $clog2(STREAM_COUNT) : 1,
    parameter int unsigned AGE_LIMIT    = 15
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0]   s_data_in,
    input  logic [STREAM_COUNT-1:0][T_QOS_WIDTH-1:0]    s_qos_in,
    input  logic [STREAM_COUNT-1:0]                     s_last_in,
    input  logic [STREAM_COUNT-1:0]                     s_valid_in,
    output logic [STREAM_COUNT-1:0]                     s_ready_out,
    output logic [T_DATA_WIDTH-1:0]                     m_data_out,
    output logic [T_QOS_WIDTH-1:0]                      m_qos_out,
    output logic [T_ID_WIDTH-1:0]                       m_id_out,
    output logic                                        m_last_out,
    output logic                                        m_valid_out,
    input  logic                                        m_ready_in
);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e                    state_q, state_d;
    logic [T_ID_WIDTH-1:0]     sel_q, sel_d;
    logic [T_QOS_WIDTH-1:0]    sel_qos_q, sel_qos_d;
    logic [T_ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
    logic [T_DATA_WIDTH-1:0]   m_data_q, m_data_d;
    logic [T_QOS_WIDTH-1:0]    m_qos_q, m_qos_d;
    logic [T_ID_WIDTH-1:0]     m_id_q, m_id_d;
    logic                      m_last_q, m_last_d;
    logic                      m_valid_q, m_valid_d;

    logic [STREAM_COUNT-1:0][T_QOS_WIDTH-1:0] eff_qos;
    logic [T_QOS_WIDTH-1:0]    max_qos;
    logic [STREAM_COUNT-1:0]   cand;
    logic                      any_cand;
    logic [T_ID_WIDTH-1:0]     win;
    logic [T_QOS_WIDTH-1:0]    win_qos;

    logic [STREAM_COUNT-1:0]   sel_onehot;
    logic                      sel_valid;
    logic                      sel_last;
    logic [T_DATA_WIDTH-1:0]   sel_data;
    logic                      out_free;

`ifdef QOS_ARB_AGING_EN
    localparam int unsigned AGE_W = $clog2(AGE_LIMIT + 1);
    logic [STREAM_COUNT-1:0][AGE_W-1:0] age_q, age_d;
`endif

    // Effective priority, candidate set and round-robin winner starting after rr_ptr
    always_comb begin : arb
        int unsigned idx;
        logic        found;
        max_qos = '0;
        cand    = '0;
        win     = rr_ptr_q;
        win_qos = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < STREAM_COUNT; i++) begin
            eff_qos[i] = s_qos_in[i];
`ifdef QOS_ARB_AGING_EN
            if (age_q[i] == AGE_W'(AGE_LIMIT)) eff_qos[i] = '1;
`endif
            if (s_valid_in[i] && (eff_qos[i] > max_qos)) max_qos = eff_qos[i];
        end
        for (int unsigned i = 0; i < STREAM_COUNT; i++) begin
            cand[i] = s_valid_in[i] && (eff_qos[i] == max_qos);
        end
        any_cand = |cand;
        for (int unsigned k = 1; k <= STREAM_COUNT; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= STREAM_COUNT) idx = idx - STREAM_COUNT;
            for (int unsigned i = 0; i < STREAM_COUNT; i++) begin
                if (!found && cand[i] && (idx == i)) begin
                    win     = T_ID_WIDTH'(i);
                    win_qos = s_qos_in[i];
                    found   = 1'b1;
                end
            end
        end
    end

    // Mux of the locked stream's inputs
    always_comb begin : sel_mux
        sel_onehot = '0;
        sel_valid  = 1'b0;
        sel_last   = 1'b0;
        sel_data   = '0;
        for (int unsigned i = 0; i < STREAM_COUNT; i++) begin
            if (sel_q == T_ID_WIDTH'(i)) begin
                sel_onehot[i] = 1'b1;
                sel_valid     = s_valid_in[i];
                sel_last      = s_last_in[i];
                sel_data      = s_data_in[i];
            end
        end
    end

    // Next state, output register loading and slave ready
    always_comb begin : next
        state_d     = state_q;
        sel_d       = sel_q;
        sel_qos_d   = sel_qos_q;
        rr_ptr_d    = rr_ptr_q;
        m_data_d    = m_data_q;
        m_qos_d     = m_qos_q;
        m_id_d      = m_id_q;
        m_last_d    = m_last_q;
        m_valid_d   = m_valid_q;
        s_ready_out = '0;
        out_free    = !m_valid_q || m_ready_in;
        if (m_ready_in) m_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_cand) begin
                    state_d   = LOCKED;
                    sel_d     = win;
                    sel_qos_d = win_qos;
                end
            end
            LOCKED: begin
                if (out_free) s_ready_out = sel_onehot;
                if (out_free && sel_valid) begin
                    m_data_d  = sel_data;
                    m_last_d  = sel_last;
                    m_id_d    = sel_q;
                    m_qos_d   = sel_qos_q;
                    m_valid_d = 1'b1;
                    if (sel_last) begin
                        state_d  = IDLE;
                        rr_ptr_d = sel_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin : regs
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            sel_qos_q <= '0;
            rr_ptr_q  <= T_ID_WIDTH'(STREAM_COUNT - 1);
            m_data_q  <= '0;
            m_qos_q   <= '0;
            m_id_q    <= '0;
            m_last_q  <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            sel_qos_q <= sel_qos_d;
            rr_ptr_q  <= rr_ptr_d;
            m_data_q  <= m_data_d;
            m_qos_q   <= m_qos_d;
            m_id_q    <= m_id_d;
            m_last_q  <= m_last_d;
            m_valid_q <= m_valid_d;
        end
    end

`ifdef QOS_ARB_AGING_EN
    // Losers that were valid age by one per grant (saturating); the winner restarts at zero
    always_comb begin : age_next
        age_d = age_q;
        if ((state_q == IDLE) && any_cand) begin
            for (int unsigned i = 0; i < STREAM_COUNT; i++) begin
                if (win == T_ID_WIDTH'(i)) begin
                    age_d[i] = '0;
                end else if (s_valid_in[i] && (age_q[i] != AGE_W'(AGE_LIMIT))) begin
                    age_d[i] = age_q[i] + AGE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : age_regs
        if (!rst_n) age_q <= '0;
        else        age_q <= age_d;
    end
`endif

    assign m_data_out  = m_data_q;
    assign m_qos_out   = m_qos_q;
    assign m_id_out    = m_id_q;
    assign m_last_out  = m_last_q;
    assign m_valid_out = m_valid_q;

endmodule

// File: tb/tb_qos_packet_arbiter.sv
// Self-checking bench for qos_packet_arbiter: directed timing checks plus randomized packet
// traffic scored against a packet-level arbitration model.
`timescale 1ns/1ps
module tb_qos_packet_arbiter;

    localparam int unsigned DW      = 32;
    localparam int unsigned QW      = 4;
    localparam int unsigned N       = 4;
    localparam int unsigned IDW     = 2;
    localparam int          AGE_LIM = 3;
`ifdef QOS_ARB_AGING_EN
    localparam bit AGING = 1'b1;
`else
    localparam bit AGING = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic [QW-1:0] qos;
        logic          last;
        logic          first;
        logic          pause;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0]  data;
        logic [QW-1:0]  qos;
        logic [IDW-1:0] id;
        logic           last;
    } out_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0][DW-1:0] s_data_in = '0;
    logic [N-1:0][QW-1:0] s_qos_in = '0;
    logic [N-1:0]         s_last_in = '0;
    logic [N-1:0]         s_valid_in = '0;
    logic [N-1:0]         s_ready_out;
    logic [DW-1:0]        m_data_out;
    logic [QW-1:0]        m_qos_out;
    logic [IDW-1:0]       m_id_out;
    logic                 m_last_out;
    logic                 m_valid_out;
    logic                 m_ready_in = 1'b1;

    qos_packet_arbiter #(
        .T_DATA_WIDTH(DW), .T_QOS_WIDTH(QW), .STREAM_COUNT(N),
        .T_ID_WIDTH(IDW), .AGE_LIMIT(AGE_LIM)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data_in(s_data_in), .s_qos_in(s_qos_in), .s_last_in(s_last_in),
        .s_valid_in(s_valid_in), .s_ready_out(s_ready_out),
        .m_data_out(m_data_out), .m_qos_out(m_qos_out), .m_id_out(m_id_out),
        .m_last_out(m_last_out), .m_valid_out(m_valid_out), .m_ready_in(m_ready_in)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    beat_t src_q [N][$];
    beat_t mdl_q [N][$];
    out_t  exp_q [$];
    int    got_ids [$];
    int    mdl_rr;
    int    mdl_age [N];
    int    gap_cnt [N];
    bit    pause_done [N];
    int    ready_mode;
    int    cyc;
    bit    prev_stalled;
    out_t  prev_out;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_valid_in = '0; s_data_in = '0; s_qos_in = '0; s_last_in = '0;
        m_ready_in = 1'b1; ready_mode = 0; cyc = 0; prev_stalled = 1'b0;
        for (int i = 0; i < N; i++) begin
            src_q[i].delete(); mdl_q[i].delete();
            mdl_age[i] = 0; gap_cnt[i] = 0; pause_done[i] = 1'b0;
        end
        mdl_rr = N - 1;
        exp_q.delete(); got_ids.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // Queue one packet on a source; non-first beats carry random QoS that must be ignored
    task automatic add_packet(input int s, input int len, input int q, input bit rand_pause, input int pause_at);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data  = $urandom;
            b.qos   = (k == 0) ? QW'(q) : QW'($urandom);
            b.last  = (k == len - 1);
            b.first = (k == 0);
            b.pause = (k > 0) && ((k == pause_at) || (rand_pause && ($urandom_range(0, 5) == 0)));
            src_q[s].push_back(b);
            mdl_q[s].push_back(b);
        end
    endtask

    // Packet-level reference: every pending stream contends; highest QoS wins, ties by rotation
    task automatic model_run();
        int    eff [N];
        int    maxq;
        int    win;
        int    idx;
        beat_t b;
        out_t  o;
        logic [QW-1:0] q;
        while (1) begin
            maxq = -1;
            win  = -1;
            for (int i = 0; i < N; i++) begin
                eff[i] = 0;
                if (mdl_q[i].size() > 0) begin
                    eff[i] = (AGING && mdl_age[i] == AGE_LIM) ? (1 << QW) - 1 : int'(mdl_q[i][0].qos);
                    if (eff[i] > maxq) maxq = eff[i];
                end
            end
            if (maxq < 0) break;
            for (int k = 1; k <= N; k++) begin
                idx = (mdl_rr + k) % N;
                if (win < 0 && mdl_q[idx].size() > 0 && eff[idx] == maxq) win = idx;
            end
            for (int i = 0; i < N; i++) begin
                if (i == win) mdl_age[i] = 0;
                else if (mdl_q[i].size() > 0 && mdl_age[i] < AGE_LIM) mdl_age[i]++;
            end
            q = mdl_q[win][0].qos;
            do begin
                b = mdl_q[win].pop_front();
                o.data = b.data; o.qos = q; o.id = IDW'(win); o.last = b.last;
                exp_q.push_back(o);
            end while (!b.last);
            mdl_rr = win;
        end
    endtask

    task automatic drive_inputs();
        beat_t hd;
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() == 0) begin
                s_valid_in[i] = 1'b0;
            end else begin
                hd = src_q[i][0];
                if (gap_cnt[i] == 0 && hd.pause && !pause_done[i]) begin
                    pause_done[i] = 1'b1;
                    gap_cnt[i] = 2;
                end
                s_qos_in[i]  = hd.qos;
                s_last_in[i] = hd.last;
                if (gap_cnt[i] > 0) begin
                    s_valid_in[i] = 1'b0;
                    s_data_in[i]  = $urandom;
                    gap_cnt[i]--;
                end else begin
                    s_valid_in[i] = 1'b1;
                    s_data_in[i]  = hd.data;
                end
            end
        end
        case (ready_mode)
            1:       m_ready_in = ($urandom_range(0, 3) != 0);
            2:       m_ready_in = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: m_ready_in = 1'b1;
        endcase
    endtask

    // One cycle: score the master side at negedge, then retire accepted beats and redrive
    task automatic step();
        out_t cur;
        out_t exp;
        logic [N-1:0] acc;
        @(negedge clk);
        cur.data = m_data_out; cur.qos = m_qos_out; cur.id = m_id_out; cur.last = m_last_out;
        checks++;
        if (!$onehot0(s_ready_out)) begin
            errors++;
            $display("FAIL ready_onehot: s_ready_out=%b, required one-hot or zero", s_ready_out);
        end
        if (prev_stalled) begin
            checks++;
            if (!m_valid_out || cur !== prev_out) begin
                errors++;
                $display("FAIL stall_hold: valid=%0b out=%h, required valid=1 out=%h", m_valid_out, cur, prev_out);
            end
        end
        if (m_valid_out && m_ready_in) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL extra_beat: got data=%h id=%0d, required no beat", cur.data, cur.id);
            end else begin
                exp = exp_q.pop_front();
                if (cur !== exp) begin
                    errors++;
                    $display("FAIL out_beat: got data=%h qos=%0d id=%0d last=%0b, required data=%h qos=%0d id=%0d last=%0b",
                             cur.data, cur.qos, cur.id, cur.last, exp.data, exp.qos, exp.id, exp.last);
                end
            end
            if (cur.last) got_ids.push_back(int'(cur.id));
        end
        acc = s_valid_in & s_ready_out;
        prev_stalled = m_valid_out && !m_ready_in;
        prev_out = cur;
        tick();
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                void'(src_q[i].pop_front());
                pause_done[i] = 1'b0;
            end
        end
        drive_inputs();
    endtask

    function automatic bit sources_empty();
        for (int i = 0; i < N; i++) if (src_q[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_traffic(input int budget, input bit kick);
        int n = 0;
        if (kick) drive_inputs();
        while ((exp_q.size() > 0 || !sources_empty()) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL traffic_timeout: %0d beats still expected after %0d cycles, required 0", exp_q.size(), budget);
            for (int i = 0; i < N; i++) src_q[i].delete();
            exp_q.delete();
        end
        ready_mode = 0;
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_valid_in = '1; s_qos_in = '1; s_last_in = '0; s_data_in = '1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({m_valid_out, m_data_out, m_qos_out, m_id_out, m_last_out, s_ready_out} !== '0) begin
            errors++;
            $display("FAIL reset_values: valid=%0b data=%h qos=%0d id=%0d last=%0b ready=%b, required all 0",
                     m_valid_out, m_data_out, m_qos_out, m_id_out, m_last_out, s_ready_out);
        end
        do_reset();
    endtask

    // Stream 0: 3-beat packet then a 1-beat packet; checks exact cycle timing and the bubble
    task automatic test_latency();
        logic [DW-1:0] d [4];
        logic [39:0]   obs;
        for (int k = 0; k < 4; k++) d[k] = $urandom;
        do_reset();
        s_valid_in[0] = 1'b1; s_data_in[0] = d[0]; s_qos_in[0] = 4'd2; s_last_in[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (s_ready_out !== 4'b0000 || m_valid_out !== 1'b0) begin
            errors++; $display("FAIL lat_cycle0: ready=%b valid=%0b, required 0000/0", s_ready_out, m_valid_out);
        end
        tick();
        @(negedge clk);
        checks++;
        if (s_ready_out !== 4'b0001 || m_valid_out !== 1'b0) begin
            errors++; $display("FAIL lat_cycle1: ready=%b valid=%0b, required 0001/0", s_ready_out, m_valid_out);
        end
        tick();
        s_data_in[0] = d[1]; s_qos_in[0] = 4'd9;
        @(negedge clk);
        obs = {m_valid_out, m_data_out, m_id_out, m_qos_out, m_last_out};
        checks++;
        if (obs !== {1'b1, d[0], 2'd0, 4'd2, 1'b0}) begin
            errors++; $display("FAIL lat_beat0: got %h, required %h", obs, {1'b1, d[0], 2'd0, 4'd2, 1'b0});
        end
        tick();
        s_data_in[0] = d[2]; s_last_in[0] = 1'b1;
        @(negedge clk);
        obs = {m_valid_out, m_data_out, m_id_out, m_qos_out, m_last_out};
        checks++;
        if (obs !== {1'b1, d[1], 2'd0, 4'd2, 1'b0}) begin
            errors++; $display("FAIL lat_beat1: got %h, required %h", obs, {1'b1, d[1], 2'd0, 4'd2, 1'b0});
        end
        tick();
        s_data_in[0] = d[3]; s_qos_in[0] = 4'd6; s_last_in[0] = 1'b1;
        @(negedge clk);
        obs = {m_valid_out, m_data_out, m_id_out, m_qos_out, m_last_out};
        checks++;
        if (obs !== {1'b1, d[2], 2'd0, 4'd2, 1'b1} || s_ready_out !== 4'b0000) begin
            errors++; $display("FAIL lat_beat2_bubble: got %h ready=%b, required %h ready=0000",
                               obs, s_ready_out, {1'b1, d[2], 2'd0, 4'd2, 1'b1});
        end
        tick();
        @(negedge clk);
        checks++;
        if (s_ready_out !== 4'b0001 || m_valid_out !== 1'b0) begin
            errors++; $display("FAIL lat_regrant: ready=%b valid=%0b, required 0001/0", s_ready_out, m_valid_out);
        end
        tick();
        s_valid_in = '0;
        @(negedge clk);
        obs = {m_valid_out, m_data_out, m_id_out, m_qos_out, m_last_out};
        checks++;
        if (obs !== {1'b1, d[3], 2'd0, 4'd6, 1'b1}) begin
            errors++; $display("FAIL lat_single: got %h, required %h", obs, {1'b1, d[3], 2'd0, 4'd6, 1'b1});
        end
        tick();
    endtask

    task automatic test_qos_order();
        do_reset();
        add_packet(1, 3, 1, 1'b0, -1);
        add_packet(3, 2, 5, 1'b0, -1);
        model_run();
        run_traffic(200, 1'b1);
        checks++;
        if (got_ids.size() != 2 || got_ids[0] != 3 || got_ids[1] != 1) begin
            errors++; $display("FAIL qos_order: got %0d packets first id %0d, required 2 packets ids 3 then 1",
                               got_ids.size(), (got_ids.size() > 0) ? got_ids[0] : -1);
        end
    endtask

    task automatic test_round_robin();
        int exp_order [5] = '{0, 1, 2, 3, 0};
        do_reset();
        add_packet(0, 1, 4, 1'b0, -1);
        add_packet(0, 1, 4, 1'b0, -1);
        for (int s = 1; s < N; s++) add_packet(s, 1, 4, 1'b0, -1);
        model_run();
        run_traffic(200, 1'b1);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (k >= got_ids.size() || got_ids[k] != exp_order[k]) begin
                errors++; $display("FAIL rr_order[%0d]: got %0d, required %0d", k,
                                   (k < got_ids.size()) ? got_ids[k] : -1, exp_order[k]);
            end
        end
    endtask

    // Stalls 1,0,0,1 on the master side plus a 2-cycle valid gap; a hungrier stream arrives mid-packet
    task automatic test_stall_gap();
        do_reset();
        ready_mode = 2;
        add_packet(0, 6, 1, 1'b0, 3);
        model_run();
        drive_inputs();
        repeat (3) step();
        add_packet(2, 2, 7, 1'b0, -1);
        model_run();
        ready_mode = 2;
        run_traffic(300, 1'b0);
        checks++;
        if (got_ids.size() != 2 || got_ids[0] != 0 || got_ids[1] != 2) begin
            errors++; $display("FAIL stall_order: got %0d packets first id %0d, required ids 0 then 2",
                               got_ids.size(), (got_ids.size() > 0) ? got_ids[0] : -1);
        end
    endtask

    task automatic test_aging();
        int pos = -1;
        int want = AGING ? 3 : 6;
        do_reset();
        for (int k = 0; k < 6; k++) add_packet(2, 1, 7, 1'b0, -1);
        add_packet(1, 1, 0, 1'b0, -1);
        model_run();
        run_traffic(300, 1'b1);
        for (int k = 0; k < got_ids.size(); k++) if (pos < 0 && got_ids[k] == 1) pos = k;
        checks++;
        if (pos != want) begin
            errors++; $display("FAIL aging_position: stream 1 granted as packet %0d, required %0d", pos, want);
        end
    endtask

    task automatic test_reset_mid_packet();
        logic was_valid;
        do_reset();
        add_packet(1, 8, 3, 1'b0, -1);
        model_run();
        drive_inputs();
        repeat (4) step();
        was_valid = m_valid_out;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (was_valid !== 1'b1 ||
            {m_valid_out, m_data_out, m_qos_out, m_id_out, m_last_out, s_ready_out} !== '0) begin
            errors++; $display("FAIL reset_async: before=%0b valid=%0b data=%h id=%0d ready=%b, required before=1 then all 0",
                               was_valid, m_valid_out, m_data_out, m_id_out, s_ready_out);
        end
        do_reset();
        add_packet(3, 1, 2, 1'b0, -1);
        add_packet(2, 2, 2, 1'b0, -1);
        model_run();
        run_traffic(200, 1'b1);
        checks++;
        if (got_ids.size() == 0 || got_ids[0] != 2) begin
            errors++; $display("FAIL reset_first_grant: got id %0d, required 2",
                               (got_ids.size() > 0) ? got_ids[0] : -1);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            got_ids.delete();
            for (int s = 0; s < N; s++) begin
                int np = $urandom_range(0, 3);
                for (int p = 0; p < np; p++)
                    add_packet(s, $urandom_range(1, 4), $urandom_range(0, 3), 1'b1, -1);
            end
            model_run();
            ready_mode = $urandom_range(0, 2);
            run_traffic(2000, 1'b1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_qos_order();
        test_round_robin();
        test_stall_gap();
        test_aging();
        test_reset_mid_packet();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
